// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with held grants.
// Registered grant index plus its gated one-hot decode.
// Optional hold-timeout, compiled in with `define RR_ARB_TIMEOUT_EN: it forces
// rotation after MAX_HOLD cycles when other requesters are waiting.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // MAX_HOLD must leave room for at least one extra cycle and fit in hold_cnt.
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("rr_arbiter4: MAX_HOLD out of range 2..255");
  end

  logic [0:0] state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [1:0] idx_nxt;
  logic       valid_nxt;
  logic [3:0] gnt_nxt;
  logic [3:0] owner_oh, others, cand;
  logic [1:0] win;
  logic       win_vld;
  logic       new_grant;
  logic       to_fire;

  assign owner_oh = 4'b0001 << gnt_idx;
  assign others   = req & ~owner_oh;
  // While granted, only non-owners compete: covers both a release (owner bit
  // already low) and a forced timeout (owner excluded).
  assign cand     = (state == GRANT) ? others : req;

  // Pick the first candidate scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  always_comb begin
    win     = 2'd0;
    win_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!win_vld && cand[ptr + 2'(k)]) begin
        win     = ptr + 2'(k);
        win_vld = 1'b1;
      end
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  logic       hold_sat;

  assign hold_sat = (hold_cnt == 8'(MAX_HOLD - 1));
  assign to_fire  = hold_sat && (|others);

  // Cycles held by the current owner; cleared on a new grant and in IDLE.
  always_ff @(posedge clk) begin
    if (rst || new_grant || state_nxt == IDLE) hold_cnt <= 8'd0;
    else if (!hold_sat)                        hold_cnt <= hold_cnt + 8'd1;
  end
`else
  assign to_fire = 1'b0;
`endif

  // Next-state: grant from IDLE, hand over on release or timeout, else hold.
  always_comb begin
    state_nxt = state;
    idx_nxt   = gnt_idx;
    ptr_nxt   = ptr;
    new_grant = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) new_grant = 1'b1;
      end
      default: begin
        if (!req[gnt_idx]) begin
          if (win_vld) new_grant = 1'b1;
          else         state_nxt = IDLE;
        end else if (to_fire) begin
          new_grant = 1'b1;
        end
      end
    endcase
    if (new_grant) begin
      state_nxt = GRANT;
      idx_nxt   = win;
      ptr_nxt   = win + 2'd1;
    end
  end

  assign valid_nxt = (state_nxt == GRANT);

  // One-hot decode of the next owner, gated by validity.
  for (genvar i = 0; i < 4; i++) begin : g_dec
    assign gnt_nxt[i] = valid_nxt && (idx_nxt == 2'(i));
  end

  // All outputs registered together so they always agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
      gnt       <= 4'b0000;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt_idx   <= idx_nxt;
      gnt_valid <= valid_nxt;
      gnt       <= gnt_nxt;
    end
  end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that shares one resource slot among four masters. It produces a registered 2-bit grant index and its one-hot 2-to-4 decoded grant vector, which directly drive the select lines of downstream shared datapaths. Grants are held until the owner releases its request. An optional hold-timeout forces rotation when other requesters are waiting.

## Interface
- MAX_HOLD, default 8: maximum consecutive cycles one owner may hold the grant while others wait. Legal range 2..255; only used when the timeout is compiled in.
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req  input  4  request lines; req[i] high means requester i wants the resource.
- gnt  output  4  one-hot grant; gnt[i] high means requester i owns the resource. All zero when idle.
- gnt_idx  output  2  binary index of the current owner. Holds its last value when idle.
- gnt_valid  output  1  high while any grant is active; equals |gnt.

## Operation
- State machine has two states: IDLE (no owner) and GRANT (owner = gnt_idx).
- A round-robin pointer ptr (2 bits) sets search priority:
  - order is ptr, ptr+1, ptr+2, ptr+3, all mod 4;
  - the first requester with req high in that order wins.
- On every new grant, ptr becomes winner+1 mod 4.
- IDLE:
  - any req bit high: go to GRANT with gnt_idx = winner;
  - otherwise stay in IDLE.
- GRANT, owner's req[gnt_idx] high: keep the grant, without re-arbitration.
- GRANT, owner's req[gnt_idx] low (release):
  - if any other req bit is high, hand over directly to the winner, with no idle bubble;
  - otherwise go to IDLE.
- gnt is the 2-to-4 decode of gnt_idx, gated by gnt_valid. All three outputs are registered and change together.
- Requests from non-owners never disturb the current grant, except through the timeout.
- hold_cnt (8 bits) counts cycles of the current grant:
  - cleared on every new grant and in IDLE;
  - saturates at MAX_HOLD-1.
- Reset values: state IDLE, gnt = 4'b0000, gnt_idx = 2'b00, gnt_valid = 0, ptr = 0, hold_cnt = 0.

## Timing
- Request-to-grant latency from IDLE is 1 cycle. If req is sampled high at edge N, gnt is valid after edge N.
- Release-to-handover is 1 cycle. The owner's req is low at edge N; the new gnt appears after edge N. gnt_valid stays high with no gap.
- Release-to-idle is 1 cycle. gnt = 0 after the edge that samples the owner's req low.
- Simultaneous release and new request from another master: the other master wins at that same edge.
- If only the releasing owner re-requests in a later cycle, it is re-granted via IDLE, giving a minimum 1-cycle gap.
- Reset mid-grant: gnt = 0 and gnt_valid = 0 after the first edge with rst high. The next grant after reset follows ptr = 0 priority.
- Pointer wrap: after a grant to 3, ptr = 0.

## Configuration
- Macro RR_ARB_TIMEOUT_EN.
- Defined: when hold_cnt = MAX_HOLD-1 and any non-owner req bit is high, the grant is forcibly moved at that edge.
  - The winner is chosen in ptr order with the owner excluded.
  - The owner therefore holds at most MAX_HOLD consecutive cycles under contention.
- Defined, with no other requester: the owner keeps the grant indefinitely and hold_cnt stays saturated.
- Undefined: hold_cnt and the timeout logic are removed. The grant is released only by the owner dropping req, and MAX_HOLD is ignored.

## Test plan
- Reset: hold req = 4'b1111 with rst high for 3 cycles, so gnt = 0 throughout. Deassert rst: gnt = 4'b0001 and gnt_idx = 0 after one edge.
- Rotation: keep req = 4'b1111, and have the owner drop its bit for exactly one cycle after each 2-cycle grant. gnt must step 0001 → 0010 → 0100 → 1000 → 0001, with no idle cycles.
- Single requester: drive req = 4'b0100. gnt = 0100 and gnt_idx = 2 one cycle later. Drop req: gnt = 0 and gnt_valid = 0 one cycle later. The next req = 4'b0011 grants 0001, because ptr = 3 wraps.
- Timeout with the macro defined and MAX_HOLD = 8: hold req = 4'b0011 constant. gnt = 0001 for exactly 8 cycles, then 0010 for 8 cycles, then repeats. With the macro undefined, gnt stays 0001 indefinitely.
- Lone holder with the macro defined: hold req = 4'b1000 for 20 cycles. gnt = 1000 continuously and never drops.
- Reset mid-grant: req = 4'b0010 granted, then assert rst for 1 cycle with req unchanged. gnt = 0 after that edge. gnt = 0010 again one cycle after rst falls.
